// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// and the encoding of the sweep-clear state machine.
package regfile_mp_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sweep-clear sequencer: walks clr_addr from 1 to NUM_REGS-1, one register
// per cycle, holding busy/clr_en high for exactly NUM_REGS-1 cycles.
module regfile_clr_fsm
    import regfile_mp_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    clr_state_t        state;
    logic [ADDR_W-1:0] ptr;

    // NOTE: state and outputs use non-blocking assignment so every register
    // here updates from the values present before the edge, never from each other mid-block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        ptr   <= ADDR_W'(1);
                        state <= CLR_SWEEP;
                        busy  <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    // clr_start is deliberately not looked at here, so a sweep cannot restart.
                    if (ptr == LAST_ADDR) begin
                        state <= CLR_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= CLR_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en   = (state == CLR_SWEEP);
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 has priority), NUM_RD
// falling-edge read ports plus a debug port, per-register written flags, sweep clear.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     clr_start,
    output logic                     busy,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] flags;

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr0;
    logic              wr1;

    // Address 0 is hard-wired zero and addresses past the array do not exist.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIMIT);
    endfunction

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        return addr_ok(a) ? regs[a] : '0;
    endfunction

    function automatic logic read_flag(input logic [ADDR_W-1:0] a);
        return addr_ok(a) ? flags[a] : 1'b0;
    endfunction

    regfile_clr_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value held and infer a latch.
    always_comb begin
        wr0 = 1'b0;
        wr1 = 1'b0;
        if (!clr_en) begin
            wr0 = we0 && addr_ok(wa0);
            wr1 = we1 && addr_ok(wa1);
        end
    end

    // NOTE: the array is reset as a whole because reads must return zero right
    // after reset; that rules out mapping it onto a block RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
        end else if (clr_en) begin
            regs[clr_addr]  <= '0;
            flags[clr_addr] <= 1'b0;
        end else begin
            if (wr0) begin
                regs[wa0]  <= wd0;
                flags[wa0] <= 1'b1;
            end
            // Port 1 is assigned last so it wins a same-address collision.
            if (wr1) begin
                regs[wa1]  <= wd1;
                flags[wa1] <= 1'b1;
            end
        end
    end

    // Reads sample half a cycle after the write edge, which makes new data
    // visible without any bypass mux.
    always_ff @(negedge clk) begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] <= read_word(rd_addr[k*ADDR_W +: ADDR_W]);
            rd_valid[k]                 <= read_flag(rd_addr[k*ADDR_W +: ADDR_W]);
        end
        dbg_data <= read_word(dbg_addr);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (32 regs, 2 read ports) and a
// 24-register, 4-read-port instance driven side by side against an array model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NA = 32;
    localparam int NB = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          clr_a, clr_b, busy_a, busy_b;
    logic [2*AW-1:0] rda;
    logic [2*DW-1:0] rdd_a;
    logic [1:0]      rdv_a;
    logic [4*AW-1:0] rdb;
    logic [4*DW-1:0] rdd_b;
    logic [3:0]      rdv_b;
    logic [AW-1:0]   dbg_addr_a, dbg_addr_b;
    logic [DW-1:0]   dbg_a, dbg_b;

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NA), .NUM_RD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rda), .rd_data(rdd_a), .rd_valid(rdv_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_start(clr_a), .busy(busy_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_a)
    );

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NB), .NUM_RD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rdb), .rd_data(rdd_b), .rd_valid(rdv_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .clr_start(clr_b), .busy(busy_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_b)
    );

    // Reference: plain arrays per instance, plus "sweeping" and the next index to clear.
    logic [DW-1:0] mem [2][NA];
    bit            flg [2][NA];
    int            nregs [2] = '{NA, NB};
    bit            sweeping [2];
    int            sweep_next [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_word(input int d, input int a);
        if (a == 0 || a >= nregs[d]) return '0;
        return mem[d][a];
    endfunction

    function automatic logic model_flag(input int d, input int a);
        if (a == 0 || a >= nregs[d]) return 1'b0;
        return flg[d][a];
    endfunction

    task automatic model_edge();
        bit c;
        for (int d = 0; d < 2; d++) begin
            c = (d == 0) ? clr_a : clr_b;
            if (!rst_n) begin
                for (int i = 0; i < NA; i++) begin
                    mem[d][i] = '0;
                    flg[d][i] = 1'b0;
                end
                sweeping[d] = 1'b0;
            end else if (sweeping[d]) begin
                mem[d][sweep_next[d]] = '0;
                flg[d][sweep_next[d]] = 1'b0;
                if (sweep_next[d] == nregs[d] - 1) sweeping[d] = 1'b0;
                else sweep_next[d]++;
            end else begin
                if (c) begin
                    sweeping[d]   = 1'b1;
                    sweep_next[d] = 1;
                end
                if (we0 && wa0 != 0 && int'(wa0) < nregs[d]) begin
                    mem[d][wa0] = wd0;
                    flg[d][wa0] = 1'b1;
                end
                if (we1 && wa1 != 0 && int'(wa1) < nregs[d]) begin
                    mem[d][wa1] = wd1;
                    flg[d][wa1] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int a;
        for (int k = 0; k < 2; k++) begin
            a = int'(rda[k*AW +: AW]);
            check($sformatf("a_rd%0d_data@%0d", k, a), rdd_a[k*DW +: DW], model_word(0, a));
            check($sformatf("a_rd%0d_valid@%0d", k, a), rdv_a[k], model_flag(0, a));
        end
        for (int k = 0; k < 4; k++) begin
            a = int'(rdb[k*AW +: AW]);
            check($sformatf("b_rd%0d_data@%0d", k, a), rdd_b[k*DW +: DW], model_word(1, a));
            check($sformatf("b_rd%0d_valid@%0d", k, a), rdv_b[k], model_flag(1, a));
        end
        check("a_dbg", dbg_a, model_word(0, int'(dbg_addr_a)));
        check("b_dbg", dbg_b, model_word(1, int'(dbg_addr_b)));
        check("a_busy", busy_a, sweeping[0]);
        check("b_busy", busy_b, sweeping[1]);
    endtask

    // Inputs are set before calling; outputs are compared one tick after the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        we0   = 1'b0;
        we1   = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    logic [DW-1:0] fillv [NA];
    int            cnt;

    initial begin
        idle_inputs();
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        rda = '0; rdb = '0; dbg_addr_a = '0; dbg_addr_b = '0;

        // Reset: everything reads zero.
        rst_n = 1'b0;
        rda = {5'd9, 5'd1};
        cycle();
        cycle();
        check("reset_busy", busy_a, 1'b0);
        rst_n = 1'b1;

        // Write r5 through port 0, readable at the next falling edge.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        rda = {5'd0, 5'd5};
        cycle();
        check("r5_data", rdd_a[31:0], 32'hDEADBEEF);
        check("r5_valid", rdv_a[0], 1'b1);
        idle_inputs();

        // Same-address collision: port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
        rda = {5'd7, 5'd7};
        cycle();
        check("r7_collision", rdd_a[63:32], 32'h22222222);
        // Different addresses: both land.
        wa0 = 5'd3; wd0 = 32'h33333333;
        wa1 = 5'd4; wd1 = 32'h44444444;
        rda = {5'd4, 5'd3};
        cycle();
        check("r3_data", rdd_a[31:0], 32'h33333333);
        check("r4_data", rdd_a[63:32], 32'h44444444);

        // Writes to r0 are ignored.
        wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        rda = '0; rdb = '0;
        cycle();
        check("r0_data", rdd_a, 64'h0);
        check("r0_valid", rdv_a, 2'b00);
        check("r0_valid_b", rdv_b, 4'b0000);
        idle_inputs();

        // Fill r1..r31, then sweep.
        for (int i = 1; i < NA; i++) begin
            we0 = 1'b1; wa0 = AW'(i); fillv[i] = $urandom; wd0 = fillv[i];
            cycle();
        end
        idle_inputs();
        rda = {5'd31, 5'd1};
        clr_a = 1'b1;
        cycle();
        clr_a = 1'b0;
        cnt = busy_a ? 1 : 0;
        for (int j = 0; j < 60 && busy_a; j++) begin
            if (j == 4) begin
                we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hCAFE0031;
            end
            if (j == 9) clr_a = 1'b1;
            cycle();
            if (j == 4) check("sweep_drop_r31", rdd_a[63:32], fillv[31]);
            idle_inputs();
            if (busy_a) cnt++;
        end
        check("sweep_len", cnt, 31);
        for (int i = 0; i < NA; i++) begin
            rda = {AW'(i), AW'(i)};
            cycle();
            check($sformatf("post_sweep_r%0d", i), {rdv_a[0], rdd_a[31:0]}, 33'h0);
        end

        // Reset in the 10th cycle of a sweep aborts it.
        we0 = 1'b1; wa0 = 5'd2;  wd0 = 32'h0BADF00D;
        we1 = 1'b1; wa1 = 5'd31; wd1 = 32'h12345678;
        cycle();
        idle_inputs();
        rda = {5'd31, 5'd2};
        clr_a = 1'b1;
        cycle();
        clr_a = 1'b0;
        for (int j = 0; j < 8; j++) cycle();
        check("pre_reset_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("abort_busy", busy_a, 1'b0);
        check("abort_regs", {rdv_a, rdd_a}, 66'h0);
        cycle();
        cycle();
        check("no_restart", busy_a, 1'b0);

        // 24-register instance: in-range, past-the-end and zero addresses.
        we0 = 1'b1; wa0 = 5'd23; wd0 = 32'hA5A51234;
        we1 = 1'b1; wa1 = 5'd24; wd1 = 32'h99999999;
        cycle();
        idle_inputs();
        rdb = {5'd31, 5'd24, 5'd23, 5'd0};
        cycle();
        check("b_port0_r0", {rdv_b[0], rdd_b[31:0]}, 33'h0);
        check("b_port1_r23", {rdv_b[1], rdd_b[63:32]}, {1'b1, 32'hA5A51234});
        check("b_port2_r24", {rdv_b[2], rdd_b[95:64]}, 33'h0);
        check("b_port3_r31", {rdv_b[3], rdd_b[127:96]}, 33'h0);

        // Random traffic with occasional sweeps and resets on both instances.
        for (int n = 0; n < 1500; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = AW'($urandom_range(0, 31));
            wa1 = AW'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            clr_a = ($urandom_range(0, 59) == 0);
            clr_b = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            rda = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
            rdb = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                   AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
            dbg_addr_a = AW'($urandom_range(0, 31));
            dbg_addr_b = AW'($urandom_range(0, 31));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
